// File: rtl/cla_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cla_pipe
// Brief    : Pipelined carry look-ahead adder/subtractor with valid/ready flow.
// Revision : 1.0 - initial release
// ============================================================================
module cla_pipe #(
  parameter int DW     = 32,
  parameter int BW     = 4,
  parameter int STAGES = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic          ci_i,
  input  logic          sub_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [DW-1:0] s_o,
  output logic          co_o,
  output logic          ov_o
);

  localparam int SW = DW / STAGES;
  localparam int NG = SW / BW;
  localparam int RW = (STAGES > 1) ? DW - SW : 1;
  localparam int NR = (STAGES > 1) ? STAGES - 1 : 1;

  if (DW % (BW * STAGES) != 0) begin : g_bad_cfg
    $fatal(1, "cla_pipe: DW must be a multiple of BW*STAGES");
  end

  // Returns {carry_out, sum}. Carries inside a group are flat sums of
  // products of p/g and the group carry-in; groups ripple into each other.
  function automatic logic [SW:0] slice_add(input logic [SW-1:0] a,
                                            input logic [SW-1:0] b,
                                            input logic          cin);
    logic [SW-1:0] p;
    logic [SW-1:0] g;
    logic [SW:0]   c;
    logic          acc;
    logic          term;
    p    = a | b;
    g    = a & b;
    c    = '0;
    c[0] = cin;
    for (int gi = 0; gi < NG; gi++) begin
      for (int i = 0; i < BW; i++) begin
        acc = c[gi*BW];
        for (int m = 0; m <= i; m++) acc = acc & p[gi*BW+m];
        for (int j = 0; j <= i; j++) begin
          term = g[gi*BW+j];
          for (int m = j + 1; m <= i; m++) term = term & p[gi*BW+m];
          acc = acc | term;
        end
        c[gi*BW+i+1] = acc;
      end
    end
    return {c[SW], a ^ b ^ c[SW-1:0]};
  endfunction

  logic [STAGES-1:0] v;
  logic [STAGES:0]   adv;
  logic [DW-1:0]     res_q   [STAGES];
  logic [RW-1:0]     rem_a_q [NR];
  logic [RW-1:0]     rem_b_q [NR];
  logic [NR-1:0]     rem_c_q;
  logic              co_q;
  logic              ov_q;
  logic [DW-1:0]     b_eff;
  logic              c_eff;

  assign b_eff = sub_i ? ~b_i : b_i;
  assign c_eff = ci_i ^ sub_i;

  // An empty stage always loads, so bubbles collapse under backpressure.
  always_comb begin
    adv[STAGES] = ready_i;
    for (int k = STAGES - 1; k >= 0; k--) adv[k] = !v[k] || adv[k+1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic          up_v;
    logic [SW-1:0] sa;
    logic [SW-1:0] sb;
    logic          sc;
    logic [DW-1:0] prev;
    logic [SW-1:0] s;
    logic          cout;

    if (k == 0) begin : g_src_in
      assign up_v = valid_i;
      assign sa   = a_i[SW-1:0];
      assign sb   = b_eff[SW-1:0];
      assign sc   = c_eff;
      assign prev = '0;
    end else begin : g_src_reg
      assign up_v = v[k-1];
      assign sa   = rem_a_q[k-1][SW-1:0];
      assign sb   = rem_b_q[k-1][SW-1:0];
      assign sc   = rem_c_q[k-1];
      assign prev = res_q[k-1];
    end

    assign {cout, s} = slice_add(sa, sb, sc);

    // Results shift down one slice per stage, landing aligned after the last.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        v[k]     <= 1'b0;
        res_q[k] <= '0;
      end else if (adv[k]) begin
        v[k]     <= up_v;
        res_q[k] <= DW'({s, prev} >> SW);
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [RW-1:0] nxt_a;
      logic [RW-1:0] nxt_b;
      if (k == 0) begin : g_fwd_in
        assign nxt_a = RW'(a_i >> SW);
        assign nxt_b = RW'(b_eff >> SW);
      end else begin : g_fwd_reg
        assign nxt_a = rem_a_q[k-1] >> SW;
        assign nxt_b = rem_b_q[k-1] >> SW;
      end
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rem_a_q[k] <= '0;
          rem_b_q[k] <= '0;
          rem_c_q[k] <= 1'b0;
        end else if (adv[k]) begin
          rem_a_q[k] <= nxt_a;
          rem_b_q[k] <= nxt_b;
          rem_c_q[k] <= cout;
        end
      end
    end else begin : g_last
      // Carry into the MSB is recovered as a ^ b ^ s at that bit.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          co_q <= 1'b0;
          ov_q <= 1'b0;
        end else if (adv[k]) begin
          co_q <= cout;
          ov_q <= cout ^ (sa[SW-1] ^ sb[SW-1] ^ s[SW-1]);
        end
      end
    end
  end

  assign ready_o = adv[0];
  assign valid_o = v[STAGES-1];
  assign s_o     = res_q[STAGES-1];
  assign co_o    = co_q;
  assign ov_o    = ov_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_pipe
// Brief    : Directed and random scoreboard bench for cla_pipe (16/4/2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_pipe;
  localparam int DW     = 16;
  localparam int BW     = 4;
  localparam int STAGES = 2;

  logic          clk = 1'b0;
  logic          rst_i, valid_i, ready_o, ci_i, sub_i, valid_o, ready_i, co_o, ov_o;
  logic [DW-1:0] a_i, b_i, s_o;

  always #5 clk = ~clk;

  cla_pipe #(.DW(DW), .BW(BW), .STAGES(STAGES)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .ci_i(ci_i), .sub_i(sub_i),
    .valid_o(valid_o), .ready_i(ready_i), .s_o(s_o), .co_o(co_o), .ov_o(ov_o)
  );

  typedef struct {
    logic [DW-1:0] s;
    logic          co;
    logic          ov;
    int            acc;
    bit            seen;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   strict = 0;
  bit   use_lit = 0;
  bit   accepted = 0;
  exp_t lit;

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(logic [DW-1:0] a, logic [DW-1:0] b, logic ci, logic sub);
    exp_t e;
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int c  = ci ? 1 : 0;
    int u, sr;
    if (!sub) begin
      u = ua + ub + c; sr = sa + sb + c; e.co = (u > 65535);
    end else begin
      u = ua - ub - c; sr = sa - sb - c; e.co = (u >= 0);
    end
    e.s    = u[DW-1:0];
    e.ov   = (sr > 32767) || (sr < -32768);
    e.acc  = 0;
    e.seen = 0;
    return e;
  endfunction

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // One clock: sample at negedge, score outputs and record accepts.
  task automatic cycle();
    exp_t e;
    cyc++;
    @(negedge clk);
    if (valid_o === 1'b1) begin
      if (q.size() == 0) begin
        chk1("spurious_valid", valid_o, 1'b0);
      end else begin
        if (strict && !q[0].seen) chk16("latency", 16'(cyc - q[0].acc), 16'd2);
        q[0].seen = 1;
        chk16("sum", s_o, q[0].s);
        chk1("co", co_o, q[0].co);
        chk1("ov", ov_o, q[0].ov);
        if (ready_i && !rst_i) void'(q.pop_front());
      end
    end
    accepted = 0;
    if (valid_i && ready_o === 1'b1 && !rst_i) begin
      e      = use_lit ? lit : model(a_i, b_i, ci_i, sub_i);
      e.acc  = cyc;
      e.seen = 0;
      q.push_back(e);
      accepted = 1;
    end
    if (rst_i) q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sub,
                      input logic [15:0] s, input logic co, input logic ov);
    a_i = a; b_i = b; ci_i = ci; sub_i = sub; valid_i = 1'b1;
    lit.s = s; lit.co = co; lit.ov = ov;
    use_lit = 1;
    cycle();
    valid_i = 1'b0;
    use_lit = 0;
  endtask

  task automatic drain(input int n);
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    chk16("drained", 16'(q.size()), 16'd0);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    a_i = '0; b_i = '0; ci_i = 1'b0; sub_i = 1'b0;
    cycle();
    cycle();
    rst_i = 1'b0;
    #1;
    chk1("rst_valid", valid_o, 1'b0);
    chk16("rst_sum", s_o, 16'h0000);
    chk1("rst_co", co_o, 1'b0);
    chk1("rst_ov", ov_o, 1'b0);
    chk1("rst_ready", ready_o, 1'b1);

    // Internal carry, wrap/overflow and subtract corners
    ready_i = 1'b1;
    strict  = 1;
    send(16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0);
    drain(4);
    send(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
    send(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
    send(16'hFFFF, 16'hFFFF, 1, 0, 16'hFFFF, 1, 0);
    send(16'h0000, 16'h0001, 0, 1, 16'hFFFF, 0, 0);
    send(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);
    send(16'h0005, 16'h0003, 1, 1, 16'h0001, 1, 0);
    drain(4);

    // Back-to-back streaming
    for (int i = 0; i < 8; i++) begin
      a_i = 16'($urandom); b_i = 16'($urandom);
      ci_i = 1'($urandom); sub_i = 1'($urandom);
      valid_i = 1'b1;
      #1;
      chk1("stream_ready", ready_o, 1'b1);
      cycle();
    end
    drain(4);
    strict = 0;

    // Backpressure: ready_i low for cycles 2..5 while streaming 4 ops
    n = 0;
    for (int c = 0; c < 40 && (n < 4 || q.size() != 0); c++) begin
      ready_i = !(c >= 2 && c <= 5);
      valid_i = (n < 4);
      a_i = pick(); b_i = pick(); ci_i = 1'($urandom); sub_i = 1'($urandom);
      #1;
      if (c >= 2 && c <= 5) chk1("bp_ready_low", ready_o, 1'b0);
      cycle();
      if (accepted) n++;
    end
    chk16("bp_count", 16'(n), 16'd4);
    drain(4);

    // Bubble pattern with toggling valid and ready
    for (int c = 0; c < 24; c++) begin
      valid_i = c[0];
      ready_i = (c % 3) != 0;
      a_i = pick(); b_i = pick(); ci_i = 1'($urandom); sub_i = 1'($urandom);
      cycle();
    end
    drain(4);

    // Reset with two ops in flight
    send(16'h1234, 16'h1111, 0, 0, 16'h2345, 0, 0);
    send(16'h4000, 16'h0001, 1, 1, 16'h3FFE, 1, 0);
    ready_i = 1'b0;
    rst_i   = 1'b1;
    cycle();
    rst_i   = 1'b0;
    ready_i = 1'b1;
    #1;
    chk1("mid_rst_valid", valid_o, 1'b0);
    chk16("mid_rst_sum", s_o, 16'h0000);
    chk1("mid_rst_co", co_o, 1'b0);
    chk1("mid_rst_ov", ov_o, 1'b0);
    chk1("mid_rst_ready", ready_o, 1'b1);
    send(16'h0F0F, 16'hF0F0, 1, 0, 16'h0000, 1, 0);
    drain(5);

    // Random traffic against the reference model
    n = 0;
    for (int c = 0; c < 60000 && n < 10000; c++) begin
      valid_i = $urandom_range(0, 9) < 7;
      ready_i = $urandom_range(0, 9) < 7;
      a_i = pick(); b_i = pick(); ci_i = 1'($urandom); sub_i = 1'($urandom);
      cycle();
      if (accepted) n++;
    end
    chk16("random_count", 16'(n), 16'(10000));
    drain(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
